pipe_stage_hs: RTL
==================

Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register that supersedes the fixed-field MEM/WB latch.
- Carries an arbitrary-width data bundle plus a control bundle between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so back-pressure never forms a combinational ready path.
- Adds synchronous flush, which converts in-flight entries to bubbles, and a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32: width of data bundle (result, dout, HL, etc. concatenated by the instantiating stage).
- CTRL_W, 8: width of control bundle (regWr, multWr, memtoreg, ...). Zeroed on every reset or flush.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, input, 1: pipeline clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream stage presents an entry.
- in_ready, output, 1: stage can accept an entry. Registered.
- in_data, input, DATA_W: upstream data bundle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- out_valid, output, 1: stage holds an entry for downstream.
- out_ready, input, 1: downstream consumes this cycle.
- out_data, output, DATA_W: head entry data.
- out_ctrl, output, CTRL_W: head entry control. Forced to 0 when out_valid=0.
- flush, input, 1: synchronous kill of all held entries.
- clr_cnt, input, 1: synchronous clear of the stall counter.
- occupancy, output, 2: entries held (0..2).
- stall_cnt, output, CNT_W: count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n=0, async): state EMPTY.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0. Skid register=0.
  - Reset mid-transfer discards all entries without exception.
- Storage: a main register drives out_*; a skid register holds the overflow entry.
- Handshake events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- State EMPTY, occupancy 0:
  - acc: load main, go to ONE.
- State ONE, occupancy 1:
  - acc & pop: main <= input, stay in ONE.
  - acc & !pop: skid <= input, go to TWO.
  - pop & !acc: go to EMPTY.
  - Neither: hold.
- State TWO, occupancy 2:
  - in_ready=0, so acc cannot occur.
  - pop: main <= skid, go to ONE.
  - Otherwise: hold.
- in_ready = (state != TWO), computed from registered state only.
- Latency: an entry accepted at edge N is visible on out_* after edge N.
  - Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- Data values are held stable while out_valid=1 and out_ready=0.
- flush=1 at an edge:
  - Next state EMPTY. main and skid control bits are cleared to 0. Data contents need not be cleared.
  - Any acc in the same cycle is discarded.
  - Any pop in the same cycle still counts as consumed downstream.
  - Flush has priority over every other event.
- stall_cnt:
  - Increments at each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap-around.
  - clr_cnt=1 sets it to 0 at that edge and takes priority over the increment.
  - flush does not clear it.
- occupancy = 0/1/2 matching the EMPTY/ONE/TWO states.
- No X propagation: out_ctrl is 0 whenever out_valid=0. Downstream treats that as a NOP bubble.

Test Plan:
- Reset then stream: in_valid=1 with data 0x11,0x22,0x33 and out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after acceptance. occupancy stays 1. stall_cnt=0.
- Back-pressure: stream 0xA0,0xA1,0xA2 with out_ready=0 -> in_ready drops after 2 accepts and occupancy=2. 0xA2 is held upstream. After 3 stalled cycles with out_valid=1, stall_cnt=3. Raising out_ready yields 0xA0,0xA1,0xA2 in order.
- Flush while full: occupancy=2 with ctrl=0xFF in both entries, assert flush together with in_valid (data 0x55) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1. 0x55 never appears on the output.
- Simultaneous acc & pop in ONE: head 0x10, input 0x20, out_ready=1 -> next cycle out_data=0x20, occupancy=1.
- Counter saturation with CNT_W=3: hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt=7 and stays there. A clr_cnt pulse sets it to 0; it then resumes counting from 1 on the next stalled edge.
- Async reset mid-stream: drop rst_n between edges while occupancy=2 -> outputs go to reset values immediately without waiting for clk. After rst_n rises, the first accepted entry is the first one output.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Supports synchronous flush to bubbles and a saturating stall-cycle counter.
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic              ready_p0;
  logic [DATA_W-1:0] main_data_p0;
  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [DATA_W-1:0] skid_data_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              acc;
  logic              pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready  = ready_p0;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data_p0;
  assign out_ctrl  = out_valid ? main_ctrl_p0 : '0;
  assign occupancy = state;
  assign stall_cnt = cnt_p0;

  assign acc = in_valid & ready_p0;
  assign pop = out_valid & out_ready;

  // Stage register: main entry drives the outputs, skid holds the overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      ready_p0     <= 1'b1;
      main_data_p0 <= '0;
      main_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else if (flush) begin
      state        <= EMPTY;
      ready_p0     <= 1'b1;
      main_ctrl_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_data_p0 <= in_data;
            main_ctrl_p0 <= in_ctrl;
            state        <= ONE;
          end
          ready_p0 <= 1'b1;
        end
        ONE: begin
          if (acc && pop) begin
            main_data_p0 <= in_data;
            main_ctrl_p0 <= in_ctrl;
          end else if (acc) begin
            skid_data_p0 <= in_data;
            skid_ctrl_p0 <= in_ctrl;
            state        <= TWO;
            ready_p0     <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_data_p0 <= skid_data_p0;
            main_ctrl_p0 <= skid_ctrl_p0;
            state        <= ONE;
            ready_p0     <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          ready_p0 <= 1'b1;
        end
      endcase
    end
  end

  // Stall counter: clear wins over increment, flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (clr_cnt) begin
      cnt_p0 <= '0;
    end else if (out_valid && !out_ready) begin
      cnt_p0 <= sat_inc(cnt_p0);
    end
  end

endmodule
